// File: rtl/layer_priority_compositor.sv
// Merges NUM_LAYERS keyed object layers over the background pixel, lowest index wins.
// Latency: 2 clocks (register inputs + eff flags, then register the priority pick).
// No backpressure: one pixel accepted and one produced every clock, never stalls.
module layer_priority_compositor #(
   parameter int                   NUM_LAYERS   = 4,
   parameter int                   RGB_WIDTH    = 8,
   parameter logic [RGB_WIDTH-1:0] TRANSPARENT  = 8'hFF,
   parameter int                   BLINK_FRAMES = 16
) (
   input  logic                              clk,
   input  logic                              resetN,
   input  logic                              startOfFrame,
   input  logic [NUM_LAYERS-1:0]             layerDrawingRequest,
   input  logic [NUM_LAYERS*RGB_WIDTH-1:0]   layerRGB,
   input  logic [RGB_WIDTH-1:0]              RGB_MIF,
   input  logic [NUM_LAYERS-1:0]             enableMaskIn,
   input  logic                              enableMaskWrite,
   input  logic [NUM_LAYERS-1:0]             blinkMask,
   output logic [RGB_WIDTH-1:0]              RGBOut,
   output logic [$clog2(NUM_LAYERS+1)-1:0]   layerIndex,
   output logic                              layerHit
);

   localparam int                IDX_W    = $clog2(NUM_LAYERS+1);
   localparam int                CNT_W    = $clog2(BLINK_FRAMES+1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES-1);

   // Frame-boundary control state
   logic [NUM_LAYERS-1:0]            r_pending_mask;
   logic [NUM_LAYERS-1:0]            r_active_mask;
   logic                             r_blink_phase;
   logic [CNT_W-1:0]                 r_frame_cnt;

   // Stage 1 pipeline registers
   logic [NUM_LAYERS-1:0]            r_eff;
   logic [NUM_LAYERS*RGB_WIDTH-1:0]  r_layer_rgb;
   logic [RGB_WIDTH-1:0]             r_mif;

   // Combinational helpers
   logic [NUM_LAYERS-1:0]            w_eff;
   logic [RGB_WIDTH-1:0]             w_win_rgb;
   logic [IDX_W-1:0]                 w_win_idx;
   logic                             w_win_hit;

   // Shadowed enable mask: writes land in pending, frame start promotes pending to active;
   // a write coinciding with frame start is promoted directly so it is not lost for a frame.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_pending_mask <= '1;
         r_active_mask  <= '1;
      end else begin
         if (enableMaskWrite)
            r_pending_mask <= enableMaskIn;
         if (startOfFrame)
            r_active_mask <= enableMaskWrite ? enableMaskIn : r_pending_mask;
      end
   end

   // Blink counter: phase toggles once every BLINK_FRAMES frame starts
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_frame_cnt   <= '0;
         r_blink_phase <= 1'b1;
      end else if (startOfFrame) begin
         if (r_frame_cnt == CNT_LAST) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
         end
      end
   end

   // Per-layer "really drawn" flag, using mask/phase as they were before this edge
   always_comb begin
      w_eff = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         w_eff[i] = layerDrawingRequest[i] & r_active_mask[i]
                  & ~(blinkMask[i] & ~r_blink_phase)
                  & (layerRGB[i*RGB_WIDTH +: RGB_WIDTH] != TRANSPARENT);
      end
   end

   // Stage 1: capture flags and colours
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_eff       <= '0;
         r_layer_rgb <= '0;
         r_mif       <= '0;
      end else begin
         r_eff       <= w_eff;
         r_layer_rgb <= layerRGB;
         r_mif       <= RGB_MIF;
      end
   end

   // Priority pick: scan from lowest priority upward so the lowest set index overrides
   always_comb begin
      w_win_rgb = r_mif;
      w_win_idx = IDX_W'(NUM_LAYERS);
      w_win_hit = 1'b0;
      for (int i = NUM_LAYERS-1; i >= 0; i--) begin
         if (r_eff[i]) begin
            w_win_rgb = r_layer_rgb[i*RGB_WIDTH +: RGB_WIDTH];
            w_win_idx = IDX_W'(i);
            w_win_hit = 1'b1;
         end
      end
   end

   // Stage 2: register the composited pixel
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         RGBOut     <= '0;
         layerIndex <= '0;
         layerHit   <= 1'b0;
      end else begin
         RGBOut     <= w_win_rgb;
         layerIndex <= w_win_idx;
         layerHit   <= w_win_hit;
      end
   end

endmodule

// File: tb/tb_layer_priority_compositor.sv
// Bench for layer_priority_compositor: table vectors, hand sequences, random vs. model.
// Latency: checks each pixel 2 clocks after it is driven.
// No backpressure on the DUT; stimulus is one pixel per clock.
module tb_layer_priority_compositor;

   localparam int NL = 4;
   localparam int BF = 2;

   typedef struct packed {
      logic [7:0] rgb;
      logic [2:0] idx;
      logic       hit;
   } exp_t;

   typedef struct packed {
      logic [3:0]      req;
      logic [3:0][7:0] rgb;
      logic [7:0]      mif;
      exp_t            ex;
   } vec_t;

   logic            clk = 1'b0;
   logic            resetN;
   logic            startOfFrame;
   logic [3:0]      layerDrawingRequest;
   logic [3:0][7:0] layer_rgb;
   logic [7:0]      RGB_MIF;
   logic [3:0]      enableMaskIn;
   logic            enableMaskWrite;
   logic [3:0]      blinkMask;
   logic [7:0]      RGBOut;
   logic [2:0]      layerIndex;
   logic            layerHit;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state (spec-level quantities)
   logic [3:0] m_pend, m_act;
   int         m_sofs;
   exp_t       p_exp;
   bit         p_vld;
   string      p_tag, tag;

   vec_t tab[8];

   layer_priority_compositor #(
      .NUM_LAYERS(NL), .RGB_WIDTH(8), .TRANSPARENT(8'hFF), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .layerDrawingRequest(layerDrawingRequest), .layerRGB(layer_rgb),
      .RGB_MIF(RGB_MIF), .enableMaskIn(enableMaskIn),
      .enableMaskWrite(enableMaskWrite), .blinkMask(blinkMask),
      .RGBOut(RGBOut), .layerIndex(layerIndex), .layerHit(layerHit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Blink visibility: phase flips after every BF frame starts
   function automatic bit model_vis();
      return ((m_sofs / BF) % 2) == 0;
   endfunction

   function automatic exp_t model_exp();
      exp_t e;
      e = '{rgb: RGB_MIF, idx: 3'd4, hit: 1'b0};
      for (int i = NL-1; i >= 0; i--) begin
         if (layerDrawingRequest[i] && m_act[i] && !(blinkMask[i] && !model_vis())
             && layer_rgb[i] != 8'hFF)
            e = '{rgb: layer_rgb[i], idx: 3'(i), hit: 1'b1};
      end
      return e;
   endfunction

   // One pixel: pick expectation, advance model, clock, check the pixel from one step ago
   task automatic step(input bit use_tab, input exp_t tab_exp);
      exp_t cur;
      cur = use_tab ? tab_exp : model_exp();
      if (startOfFrame) begin
         m_act = enableMaskWrite ? enableMaskIn : m_pend;
         m_sofs++;
      end
      if (enableMaskWrite) m_pend = enableMaskIn;
      @(posedge clk); #1;
      if (p_vld) begin
         chk({p_tag, ".rgb"}, 32'(RGBOut),     32'(p_exp.rgb));
         chk({p_tag, ".idx"}, 32'(layerIndex), 32'(p_exp.idx));
         chk({p_tag, ".hit"}, 32'(layerHit),   32'(p_exp.hit));
      end
      p_exp = cur; p_vld = 1'b1; p_tag = tag;
   endtask

   task automatic idle_inputs();
      startOfFrame = 0; enableMaskWrite = 0; enableMaskIn = '0; blinkMask = '0;
      layerDrawingRequest = '0; layer_rgb = '0; RGB_MIF = 8'h55;
   endtask

   task automatic model_reset();
      m_pend = '1; m_act = '1; m_sofs = 0; p_vld = 1'b0;
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      @(posedge clk); #3;
      resetN = 1'b1;
      model_reset();
   endtask

   localparam exp_t E_3C  = '{rgb: 8'h3C, idx: 3'd0, hit: 1'b1};
   localparam exp_t E_AA  = '{rgb: 8'hAA, idx: 3'd0, hit: 1'b1};
   localparam exp_t E_MIF = '{rgb: 8'h55, idx: 3'd4, hit: 1'b0};

   initial begin
      exp_t e;
      bit   vis;
      tab[0] = '{req: 4'b1110, rgb: {8'h03, 8'hE0, 8'h1C, 8'h00}, mif: 8'h55, ex: '{rgb: 8'h1C, idx: 3'd1, hit: 1'b1}};
      tab[1] = '{req: 4'b0000, rgb: {8'h03, 8'hE0, 8'h1C, 8'h00}, mif: 8'h55, ex: '{rgb: 8'h55, idx: 3'd4, hit: 1'b0}};
      tab[2] = '{req: 4'b0011, rgb: {8'h00, 8'h00, 8'h20, 8'hFF}, mif: 8'h55, ex: '{rgb: 8'h20, idx: 3'd1, hit: 1'b1}};
      tab[3] = '{req: 4'b1111, rgb: {8'h03, 8'hE0, 8'h1C, 8'h42}, mif: 8'h55, ex: '{rgb: 8'h42, idx: 3'd0, hit: 1'b1}};
      tab[4] = '{req: 4'b1000, rgb: {8'h03, 8'hE0, 8'h1C, 8'h42}, mif: 8'h55, ex: '{rgb: 8'h03, idx: 3'd3, hit: 1'b1}};
      tab[5] = '{req: 4'b1000, rgb: {8'hFF, 8'hE0, 8'h1C, 8'h42}, mif: 8'hFF, ex: '{rgb: 8'hFF, idx: 3'd4, hit: 1'b0}};
      tab[6] = '{req: 4'b0100, rgb: {8'h07, 8'hFF, 8'h1C, 8'h42}, mif: 8'h12, ex: '{rgb: 8'h12, idx: 3'd4, hit: 1'b0}};
      tab[7] = '{req: 4'b1111, rgb: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, mif: 8'h9A, ex: '{rgb: 8'h9A, idx: 3'd4, hit: 1'b0}};

      idle_inputs();
      tag = "init";
      resetN = 1'b0;
      model_reset();
      #12;
      chk("reset.rgb", 32'(RGBOut), 32'h0);
      chk("reset.idx", 32'(layerIndex), 32'h0);
      chk("reset.hit", 32'(layerHit), 32'h0);
      @(posedge clk); #3;
      resetN = 1'b1;

      // Priority and keying vectors
      for (int v = 0; v < 8; v++) begin
         $sformat(tag, "tab%0d", v);
         layerDrawingRequest = tab[v].req;
         layer_rgb = tab[v].rgb;
         RGB_MIF = tab[v].mif;
         step(1'b1, tab[v].ex);
      end

      // Mask shadowing: last mid-frame write wins, applies after the next frame start
      idle_inputs();
      layerDrawingRequest = 4'b0001; layer_rgb[0] = 8'hAA;
      tag = "shadow_w1"; enableMaskWrite = 1; enableMaskIn = 4'b1111; step(1'b1, E_AA);
      tag = "shadow_w2"; enableMaskIn = 4'b1110; step(1'b1, E_AA);
      tag = "shadow_mid"; enableMaskWrite = 0; enableMaskIn = '0; step(1'b1, E_AA);
      tag = "shadow_sof"; startOfFrame = 1; step(1'b1, E_AA);
      tag = "shadow_after"; startOfFrame = 0; step(1'b1, E_MIF);
      tag = "shadow_both"; startOfFrame = 1; enableMaskWrite = 1; enableMaskIn = 4'b1111; step(1'b1, E_MIF);
      tag = "shadow_both_after"; startOfFrame = 0; enableMaskWrite = 0; enableMaskIn = '0; step(1'b1, E_AA);

      // Ramp on L2 every clock, 8'hFF keyed out
      idle_inputs();
      layerDrawingRequest = 4'b0100;
      for (int i = 0; i < 256; i++) begin
         $sformat(tag, "ramp%0d", i);
         layer_rgb[2] = 8'(i);
         if (i == 255) e = E_MIF;
         else          e = '{rgb: 8'(i), idx: 3'd2, hit: 1'b1};
         step(1'b1, e);
      end
      idle_inputs();
      tag = "ramp_flush"; step(1'b0, E_MIF);

      // Blink: frames of 4 pixels, the time before the first frame start is frame 0
      do_reset();
      idle_inputs();
      layerDrawingRequest = 4'b0001; layer_rgb[0] = 8'h3C; blinkMask = 4'b0001;
      for (int f = 0; f < 10; f++) begin
         if (f == 6) blinkMask = 4'b0000;
         for (int p = 0; p < 4; p++) begin
            $sformat(tag, "blink_f%0d_p%0d", f, p);
            startOfFrame = (f > 0 && p == 0);
            vis = ((f / 2) % 2) == 0 || f >= 6;
            if (startOfFrame && f < 6) step(1'b0, E_MIF);
            else                      step(1'b1, vis ? E_3C : E_MIF);
         end
      end
      idle_inputs();
      tag = "blink_flush"; step(1'b0, E_MIF);

      // Random pixels and control against the model
      for (int n = 0; n < 400; n++) begin
         $sformat(tag, "rand%0d", n);
         layerDrawingRequest = 4'($urandom);
         for (int i = 0; i < NL; i++)
            layer_rgb[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         RGB_MIF = 8'($urandom);
         blinkMask = 4'($urandom);
         enableMaskWrite = ($urandom_range(0, 5) == 0);
         enableMaskIn = 4'($urandom);
         startOfFrame = ($urandom_range(0, 7) == 0);
         step(1'b0, E_MIF);
      end

      // Mid-frame reset from hidden blink phase with everything masked off
      idle_inputs();
      tag = "pre_rst";
      enableMaskWrite = 1; enableMaskIn = 4'b0000; startOfFrame = 1;
      step(1'b0, E_MIF);
      enableMaskWrite = 0; startOfFrame = 0;
      for (int j = 0; j < 8 && model_vis(); j++) begin
         startOfFrame = 1; step(1'b0, E_MIF);
         startOfFrame = 0; step(1'b0, E_MIF);
      end
      layerDrawingRequest = 4'b1111; blinkMask = 4'b1111;
      layer_rgb = {8'h44, 8'h33, 8'h22, 8'h77};
      step(1'b0, E_MIF);
      step(1'b0, E_MIF);
      #3 resetN = 1'b0;
      #1;
      chk("midrst.rgb", 32'(RGBOut), 32'h0);
      chk("midrst.idx", 32'(layerIndex), 32'h0);
      chk("midrst.hit", 32'(layerHit), 32'h0);
      @(posedge clk); #1;
      chk("midrst_hold.rgb", 32'(RGBOut), 32'h0);
      chk("midrst_hold.hit", 32'(layerHit), 32'h0);
      #2 resetN = 1'b1;
      model_reset();
      tag = "post_rst";
      step(1'b1, '{rgb: 8'h77, idx: 3'd0, hit: 1'b1});
      idle_inputs();
      tag = "post_rst_idle";
      step(1'b1, E_MIF);
      step(1'b1, E_MIF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
